// File: rtl/timer_controller.sv
// Programmable timer: prescaled tick, period compare, periodic/one-shot
// modes, one-cycle expiry pulse and sticky interrupt request.
module timer_controller #(
    parameter int WIDTH          = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_oneshot,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      irq_clear,
    output logic                      busy,
    output logic [WIDTH-1:0]          count,
    output logic                      expired,
    output logic                      irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [WIDTH-1:0]          r_period;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_oneshot;
    logic [PRESCALE_WIDTH-1:0] r_prescaler;
    logic [WIDTH-1:0]          r_count;
    logic                      r_expired;
    logic                      r_irq;

    logic w_run;
    logic w_tick;
    logic w_match;
    logic w_expire;
    logic w_cfg_load;

    // Tick/expiry decode; a stop pulse freezes all running activity.
    always_comb begin
        w_run      = (r_state == S_RUN);
        w_tick     = w_run && (r_prescaler == r_prescale);
        w_match    = (r_count == r_period);
        w_expire   = w_tick && w_match && !stop;
        w_cfg_load = cfg_we && !w_run;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: stop beats start, start beats one-shot completion.
    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt = S_RUN;
        end else if (w_expire && r_oneshot) begin
            w_state_nxt = S_DONE;
        end
    end

    // Config, prescaler, main counter, expiry pulse and sticky irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period    <= '0;
            r_prescale  <= '0;
            r_oneshot   <= 1'b0;
            r_prescaler <= '0;
            r_count     <= '0;
            r_expired   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_expired <= w_expire;
            if (w_expire) begin
                r_irq <= 1'b1;
            end else if (irq_clear) begin
                r_irq <= 1'b0;
            end
            if (w_cfg_load) begin
                r_period   <= cfg_period;
                r_prescale <= cfg_prescale;
                r_oneshot  <= cfg_oneshot;
            end
            if (stop) begin
                r_count     <= r_count;
                r_prescaler <= r_prescaler;
            end else if (start) begin
                r_count     <= '0;
                r_prescaler <= '0;
            end else if (w_run) begin
                if (w_tick) begin
                    r_prescaler <= '0;
                    if (!w_match) begin
                        r_count <= r_count + 1'b1;
                    end else if (!r_oneshot) begin
                        r_count <= '0;
                    end
                end else begin
                    r_prescaler <= r_prescaler + 1'b1;
                end
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign count   = r_count;
    assign expired = r_expired;
    assign irq     = r_irq;

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: directed vector table, hand sequences,
// and random stimulus against an elapsed-time reference model.
module tb_timer_controller;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_prescale;
    logic        cfg_oneshot;
    logic        start;
    logic        stop;
    logic        irq_clear;
    logic        busy;
    logic [15:0] count;
    logic        expired;
    logic        irq;

    int n_tests;
    int n_fail;

    timer_controller #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_period  (cfg_period),
        .cfg_prescale(cfg_prescale),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .irq_clear   (irq_clear),
        .busy        (busy),
        .count       (count),
        .expired     (expired),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] n;
        logic [7:0]  p;
        logic        one;
        logic        st;
        logic        sp;
        logic        clr;
        logic        e_busy;
        logic [15:0] e_cnt;
        logic        e_exp;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    // Reference model: time elapsed since entering RUN determines everything.
    int m_state;
    int m_e;
    int m_n;
    int m_p;
    int m_one;
    int m_count;
    int m_exp;
    int m_irq;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        cfg_we = 0; cfg_period = 0; cfg_prescale = 0; cfg_oneshot = 0;
        start = 0; stop = 0; irq_clear = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_e = 0; m_n = 0; m_p = 0; m_one = 0;
        m_count = 0; m_exp = 0; m_irq = 0;
    endtask

    task automatic model_step();
        int len;
        int e;
        int run;
        run = (m_state == 1);
        len = (m_n + 1) * (m_p + 1);
        e = m_e + 1;
        m_exp = (run && !stop && e == len) ? 1 : 0;
        if (m_exp == 1) m_irq = 1;
        else if (irq_clear) m_irq = 0;
        if (stop) begin
            m_state = 0;
        end else if (start) begin
            m_state = 1;
            m_e = 0;
            m_count = 0;
        end else if (run) begin
            if (m_one == 1) begin
                m_count = (e == len) ? m_n : e / (m_p + 1);
                m_e = e;
                if (e == len) m_state = 2;
            end else begin
                m_count = (e / (m_p + 1)) % (m_n + 1);
                m_e = e % len;
            end
        end
        if (cfg_we && !run) begin
            m_n = int'(cfg_period);
            m_p = int'(cfg_prescale);
            m_one = int'(cfg_oneshot);
        end
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail = 0;
        idle();
        reset = 0;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);
        chk("reset_expired", expired, 0);
        chk("reset_irq", irq, 0);
        reset = 1;

        tbl.push_back('{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0});
        tbl.push_back('{1, 7, 0, 0, 0, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            cfg_we = tbl[i].we;
            cfg_period = tbl[i].n;
            cfg_prescale = tbl[i].p;
            cfg_oneshot = tbl[i].one;
            start = tbl[i].st;
            stop = tbl[i].sp;
            irq_clear = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_expired", i), expired, tbl[i].e_exp);
            chk($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
        end
        idle();

        // New period of 7 now in force: expiry on the eighth tick.
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("n7_count%0d", i), count, i % 8);
            chk($sformatf("n7_expired%0d", i), expired, (i == 8) ? 1 : 0);
        end

        // start+stop together from IDLE stays IDLE; restart mid-run.
        stop = 1;
        step();
        chk("stop_busy", busy, 0);
        start = 1;
        step();
        chk("startstop_busy", busy, 0);
        stop = 0;
        step();
        chk("start_busy", busy, 1);
        chk("start_count", count, 0);
        start = 0;
        step();
        step();
        chk("pre_restart_count", count, 2);
        start = 1;
        step();
        chk("restart_count", count, 0);
        chk("restart_busy", busy, 1);
        start = 0;

        // One-shot P=2, N=1: expiry exactly 6 cycles after RUN entry.
        stop = 1;
        irq_clear = 1;
        step();
        idle();
        cfg_we = 1; cfg_period = 1; cfg_prescale = 2; cfg_oneshot = 1;
        step();
        idle();
        start = 1;
        step();
        start = 0;
        n = 0;
        do begin
            step();
            n++;
        end while (!expired && n < 20);
        chk("oneshot_latency", n, 6);
        chk("oneshot_busy", busy, 0);
        chk("oneshot_count", count, 1);
        chk("oneshot_irq", irq, 1);
        step();
        chk("oneshot_expired_once", expired, 0);
        chk("oneshot_hold_count", count, 1);

        // Asynchronous reset in the middle of a running period.
        cfg_we = 1; cfg_period = 3; cfg_prescale = 0; cfg_oneshot = 0;
        step();
        idle();
        start = 1;
        step();
        start = 0;
        repeat (6) step();
        chk("prereset_irq", irq, 1);
        #3;
        reset = 0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_count", count, 0);
        chk("async_expired", expired, 0);
        chk("async_irq", irq, 0);
        step();
        reset = 1;
        model_reset();

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_period = 16'($urandom_range(0, 6));
            cfg_prescale = 8'($urandom_range(0, 3));
            cfg_oneshot = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop = ($urandom_range(0, 31) == 0);
            irq_clear = ($urandom_range(0, 7) == 0);
            model_step();
            step();
            chk("rnd_busy", busy, (m_state == 1) ? 1 : 0);
            chk("rnd_count", count, m_count);
            chk("rnd_expired", expired, m_exp);
            chk("rnd_irq", irq, m_irq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
